instruction_fetch: RTL and testbench
====================================

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter IMEM_DEPTH, default 64: number of 32-bit words in the internal instruction memory; power of two, 4..256.
REQ-002 Parameter RESET_PC, default 32'h00000000: byte address of the first fetch after start.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load_en  input  1  write enable for the instruction memory load port.
REQ-006 load_addr  input  log2(IMEM_DEPTH)  word index to write.
REQ-007 load_data  input  32  instruction word to write.
REQ-008 start  input  1  single-cycle pulse; begins fetching at RESET_PC.
REQ-009 stall  input  1  pipeline back-pressure; hold the current fetch output.
REQ-010 branch_taken  input  1  redirect request from a later pipeline stage.
REQ-011 branch_target  input  32  byte address of the redirect.
REQ-012 Instruction  output  32  fetched word; drives the pipeline instruction input.
REQ-013 pc_out  output  32  byte address of the word on Instruction.
REQ-014 instr_valid  output  1  Instruction is a real fetched word, not a bubble.
REQ-015 halted  output  1  fetch unit is in HALT.

Function
REQ-016 The block SHALL implement FSM states IDLE, FETCH and HALT, with IDLE entered on reset.
REQ-017 IDLE SHALL go to FETCH on start=1; FETCH SHALL go to HALT when the internal pc is >= 4*IMEM_DEPTH; HALT SHALL go to FETCH on start=1; no other transitions exist.
REQ-018 On start, the internal pc SHALL load RESET_PC, and the first fetched word SHALL appear one cycle later.
REQ-019 In FETCH with stall=0 and branch_taken=0, each cycle SHALL set Instruction=imem[pc[k+1:2]] (k=log2 IMEM_DEPTH), pc_out=pc, instr_valid=1, and pc=pc+4.
REQ-020 Fetch latency SHALL be exactly one cycle from pc update to the matching Instruction/pc_out registration.
REQ-021 With stall=1 and branch_taken=0, pc, Instruction, pc_out and instr_valid SHALL hold their values.
REQ-022 branch_taken=1 SHALL take priority over stall: pc=branch_target with bits [1:0] forced to 0, Instruction=32'h0, and instr_valid=0 for that cycle (one-cycle bubble); fetching SHALL resume from the target on the next cycle.
REQ-023 A branch_target that is >= 4*IMEM_DEPTH SHALL be accepted, and the next cycle SHALL enter HALT.
REQ-024 On entering HALT, Instruction SHALL be 32'h0, instr_valid SHALL be 0 and halted SHALL be 1, and pc_out SHALL hold the last valid address; in HALT, stall and branch_taken SHALL be ignored.
REQ-025 In IDLE and HALT, load_en=1 SHALL write load_data to imem[load_addr]; in FETCH, load_en SHALL be ignored.
REQ-026 start asserted while in FETCH SHALL be ignored.
REQ-027 pc arithmetic SHALL be 32-bit unsigned, and pc SHALL NOT wrap; the HALT check of REQ-017 prevents wrap.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, pc=RESET_PC, Instruction=0, pc_out=0, instr_valid=0 and halted=0, regardless of the clock.
REQ-029 Reset SHALL NOT clear the instruction memory contents.
REQ-030 Reset asserted mid-FETCH SHALL abort the current fetch with no further valid outputs until the next start.

Verification
REQ-031 Load imem[0..3] = 32'h00E91020, 32'h8CE50006, 32'hACA20004, 32'h104A1822, then pulse start -> on four consecutive cycles Instruction shows those words, pc_out = 0, 4, 8, 12 and instr_valid=1.
REQ-032 Hold stall=1 for 3 cycles after the second word -> Instruction=32'h8CE50006 and pc_out=4 are held for 3 cycles, then 32'hACA20004 appears at pc_out=8.
REQ-033 Assert branch_taken with branch_target=32'h0000000E while stall=1 -> one cycle with instr_valid=0 and Instruction=0, then pc_out=12 and Instruction=32'h104A1822.
REQ-034 With IMEM_DEPTH=4, run past word 3 -> halted=1, instr_valid=0 and Instruction=0 are stable; a start pulse then restarts at pc_out=0.
REQ-035 Drive rst_n low between clock edges mid-FETCH -> outputs clear without a clock edge; memory contents are intact, and start replays the program from pc_out=0.
REQ-036 Assert load_en during FETCH with load_addr=1 and load_data=32'hFFFFFFFF -> memory is unchanged, and word 1 still reads 32'h8CE50006 after restart.

Source files
------------

// File: rtl/instruction_fetch.sv
// ----------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage with a private instruction memory. The memory is loaded while
// the unit is not fetching (IDLE or HALT); a start pulse then fetches
// sequential words from RESET_PC, one per cycle, until the pc runs past the
// end of the memory, at which point the unit parks in HALT.
//
// State   | meaning
// --------+-------------------------------------------------------------
// IDLE    | after reset; memory loadable, waiting for start
// FETCH   | fetching one word per cycle; stall holds, branch inserts bubble
// HALT    | pc ran past memory end; memory loadable, start restarts
//
// Ports
//   clk            single clock, rising edge
//   rst_n          asynchronous active-low reset (memory is not cleared)
//   load_en        memory write enable (honoured in IDLE/HALT only)
//   load_addr      word index to write
//   load_data      word to write
//   start          pulse; (re)starts fetching at RESET_PC
//   stall          hold the current fetch output and pc
//   branch_taken   redirect pc to branch_target (wins over stall)
//   branch_target  byte address of the redirect
//   Instruction    fetched word (0 when a bubble)
//   pc_out         byte address of the word on Instruction
//   instr_valid    Instruction holds a real fetched word
//   halted         unit is in HALT
// ----------------------------------------------------------------------------
module instruction_fetch #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_en,
    input  logic [$clog2(IMEM_DEPTH)-1:0] load_addr,
    input  logic [31:0]                   load_data,
    input  logic                          start,
    input  logic                          stall,
    input  logic                          branch_taken,
    input  logic [31:0]                   branch_target,
    output logic [31:0]                   Instruction,
    output logic [31:0]                   pc_out,
    output logic                          instr_valid,
    output logic                          halted
);

    localparam int          AW       = $clog2(IMEM_DEPTH);
    localparam logic [31:0] PC_LIMIT = 32'(4 * IMEM_DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nx;

    logic [31:0]   pc;
    logic [31:0]   pc_nx;
    logic [31:0]   instr_nx;
    logic [31:0]   pc_out_nx;
    logic          valid_nx;

    logic [31:0]   imem [IMEM_DEPTH];
    logic [AW-1:0] rd_idx;
    logic          past_end;

    assign rd_idx   = pc[AW+1:2];
    // The end-of-memory check is what keeps pc from ever wrapping.
    assign past_end = (pc >= PC_LIMIT);

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start)    state_nx = FETCH;
            FETCH:   if (past_end) state_nx = HALT;
            HALT:    if (start)    state_nx = FETCH;
            default:               state_nx = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath next values (pc and registered fetch outputs)
    // ------------------------------------------------------------------
    always_comb begin
        pc_nx     = pc;
        instr_nx  = Instruction;
        pc_out_nx = pc_out;
        valid_nx  = instr_valid;
        case (state)
            IDLE, HALT: begin
                if (start) begin
                    pc_nx = RESET_PC;
                end
            end
            FETCH: begin
                if (past_end) begin
                    // Entering HALT: bubble out, pc_out keeps last valid address.
                    instr_nx = 32'h0;
                    valid_nx = 1'b0;
                end else if (branch_taken) begin
                    pc_nx    = branch_target & ~32'h3;
                    instr_nx = 32'h0;
                    valid_nx = 1'b0;
                end else if (!stall) begin
                    instr_nx  = imem[rd_idx];
                    pc_out_nx = pc;
                    valid_nx  = 1'b1;
                    pc_nx     = pc + 32'd4;
                end
            end
            default: begin
                instr_nx = 32'h0;
                valid_nx = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            Instruction <= 32'h0;
            pc_out      <= 32'h0;
            instr_valid <= 1'b0;
        end else begin
            pc          <= pc_nx;
            Instruction <= instr_nx;
            pc_out      <= pc_out_nx;
            instr_valid <= valid_nx;
        end
    end

    assign halted = (state == HALT);

    // Memory has no reset so a program survives rst_n; writes are locked
    // out while fetching.
    always_ff @(posedge clk) begin
        if (load_en && (state != FETCH)) begin
            imem[load_addr] <= load_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        load_en;
    logic [1:0]  load_addr;
    logic [31:0] load_data;
    logic        start;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic [31:0] Instruction;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        halted;

    instruction_fetch #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .load_en       (load_en),
        .load_addr     (load_addr),
        .load_data     (load_data),
        .start         (start),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .Instruction   (Instruction),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        stl;
        logic        br;
        logic [31:0] tgt;
        logic        ld;
        logic [1:0]  la;
        logic [31:0] ldat;
        logic [31:0] e_instr;
        logic [31:0] e_pc;
        logic        e_valid;
        logic        e_halt;
    } vec_t;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        halt;
    } exp_t;

    vec_t tab_main[$];
    vec_t tab_post[$];
    exp_t sb[$];

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [31:0] W0 = 32'h00E91020;
    localparam logic [31:0] W1 = 32'h8CE50006;
    localparam logic [31:0] W2 = 32'hACA20004;
    localparam logic [31:0] W3 = 32'h104A1822;
    localparam logic [31:0] WN = 32'hDEADBEEF;

    function automatic vec_t v(logic st, logic stl, logic br, logic [31:0] tgt,
                               logic ld, logic [1:0] la, logic [31:0] ldat,
                               logic [31:0] ei, logic [31:0] ep, logic ev, logic eh);
        vec_t r;
        r.st = st; r.stl = stl; r.br = br; r.tgt = tgt;
        r.ld = ld; r.la = la; r.ldat = ldat;
        r.e_instr = ei; r.e_pc = ep; r.e_valid = ev; r.e_halt = eh;
        return r;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step(vec_t t, int idx);
        exp_t e;
        @(negedge clk);
        start         = t.st;
        stall         = t.stl;
        branch_taken  = t.br;
        branch_target = t.tgt;
        load_en       = t.ld;
        load_addr     = t.la;
        load_data     = t.ldat;
        e.instr = t.e_instr; e.pc = t.e_pc; e.valid = t.e_valid; e.halt = t.e_halt;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check($sformatf("sb_empty[%0d]", idx), 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check($sformatf("instr[%0d]", idx), Instruction, e.instr);
            check($sformatf("pc_out[%0d]", idx), pc_out, e.pc);
            check($sformatf("valid[%0d]", idx), {31'b0, instr_valid}, {31'b0, e.valid});
            check($sformatf("halted[%0d]", idx), {31'b0, halted}, {31'b0, e.halt});
        end
    endtask

    initial begin
        // Load program in IDLE, then run the fetch/stall/branch/halt scenarios.
        tab_main.push_back(v(0,0,0,0, 1,2'd0,W0, 0,0,0,0));
        tab_main.push_back(v(0,0,0,0, 1,2'd1,W1, 0,0,0,0));
        tab_main.push_back(v(0,0,0,0, 1,2'd2,W2, 0,0,0,0));
        tab_main.push_back(v(0,0,0,0, 1,2'd3,W3, 0,0,0,0));
        tab_main.push_back(v(1,0,0,0, 0,0,0,     0,0,0,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     W0,0,1,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     W1,4,1,0));
        tab_main.push_back(v(0,1,0,0, 0,0,0,     W1,4,1,0));
        tab_main.push_back(v(0,1,0,0, 0,0,0,     W1,4,1,0));
        tab_main.push_back(v(0,1,0,0, 0,0,0,     W1,4,1,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     W2,8,1,0));
        // branch wins over stall, low bits of target dropped
        tab_main.push_back(v(0,1,1,32'h0000000E, 0,0,0, 0,8,0,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     W3,12,1,0));
        // run off the end -> HALT, then HALT ignores stall/branch
        tab_main.push_back(v(0,0,0,0, 0,0,0,     0,12,0,1));
        tab_main.push_back(v(0,1,1,32'h0, 0,0,0, 0,12,0,1));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     0,12,0,1));
        // restart from HALT; load and start during FETCH ignored
        tab_main.push_back(v(1,0,0,0, 0,0,0,     0,12,0,0));
        tab_main.push_back(v(0,0,0,0, 1,2'd1,32'hFFFFFFFF, W0,0,1,0));
        tab_main.push_back(v(1,0,0,0, 0,0,0,     W1,4,1,0));
        // out-of-range branch target accepted, then HALT
        tab_main.push_back(v(0,0,1,32'h00000100, 0,0,0, 0,4,0,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     0,4,0,1));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     0,4,0,1));
        // load honoured in HALT
        tab_main.push_back(v(0,0,0,0, 1,2'd2,WN, 0,4,0,1));
        tab_main.push_back(v(1,0,0,0, 0,0,0,     0,4,0,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     W0,0,1,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     W1,4,1,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     WN,8,1,0));
        // unstalled branch back to word 1
        tab_main.push_back(v(0,0,1,32'h00000004, 0,0,0, 0,8,0,0));
        tab_main.push_back(v(0,0,0,0, 0,0,0,     W1,4,1,0));

        // After async reset: IDLE, memory intact, program replays from 0.
        tab_post.push_back(v(0,0,0,0, 0,0,0,     0,0,0,0));
        tab_post.push_back(v(1,0,0,0, 0,0,0,     0,0,0,0));
        tab_post.push_back(v(0,0,0,0, 0,0,0,     W0,0,1,0));
        tab_post.push_back(v(0,0,0,0, 0,0,0,     W1,4,1,0));
        tab_post.push_back(v(0,0,0,0, 0,0,0,     WN,8,1,0));
        tab_post.push_back(v(0,0,0,0, 0,0,0,     W3,12,1,0));
        tab_post.push_back(v(0,0,0,0, 0,0,0,     0,12,0,1));

        rst_n = 1'b0;
        start = 0; stall = 0; branch_taken = 0; branch_target = 0;
        load_en = 0; load_addr = 0; load_data = 0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_instr", Instruction, 32'h0);
        check("rst_pc_out", pc_out, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'h0);
        check("rst_halted", {31'b0, halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tab_main.size(); i++) step(tab_main[i], i);

        // Mid-FETCH async reset between edges: outputs clear with no clock edge.
        check("pre_rst_valid", {31'b0, instr_valid}, 32'h1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_instr", Instruction, 32'h0);
        check("arst_pc_out", pc_out, 32'h0);
        check("arst_valid", {31'b0, instr_valid}, 32'h0);
        check("arst_halted", {31'b0, halted}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < tab_post.size(); i++) step(tab_post[i], 100 + i);

        check("sb_drained", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
